// File: rtl/rate_divider_bank_pkg.sv
// Shared widths, standard divide ratios and the reset-divisor packer for the divider bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_pkg;

   localparam int CNT_W      = 32;
   localparam int DEF_NUM_CH = 4;

   typedef logic [CNT_W-1:0] div_t;

   // Standard rates from the master clock
   localparam div_t VGA_DIV  = div_t'(2);
   localparam div_t SEG_DIV  = div_t'(100);
   localparam div_t HZ1_DIV  = div_t'(2000);
   localparam div_t CHAR_DIV = div_t'(8000);

   // Pack four per-channel divisors, channel 0 in the least significant slot
   function automatic logic [DEF_NUM_CH*CNT_W-1:0] packDefDiv(
      input div_t d0,
      input div_t d1,
      input div_t d2,
      input div_t d3
   );
      return {d3, d2, d1, d0};
   endfunction

endpackage

// File: rtl/rate_divider_bank_if.sv
// Control and strobe bundle between a divider bank and its user.
// Latency: n/a (wires only).
// Backpressure: none; strobes are free-running, writes always accepted.
interface rate_divider_bank_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   import clk_div_pkg::*;

   logic              en;
   logic              sync;
   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] square;
   logic [NUM_CH-1:0] active;

   modport master (
      output en, sync, cfg_we, cfg_ch, cfg_div,
      input  tick, square, active
   );

   modport slave (
      input  en, sync, cfg_we, cfg_ch, cfg_div,
      output tick, square, active
   );

endinterface

// File: rtl/rate_divider_bank_div_channel.sv
// One integer divider: up-counter with active/pending divisor, tick strobe and square output.
// Latency: tick registered on the Nth enabled edge after a restart; divisor swaps at terminal count.
// Backpressure: none; en=0 freezes the count, writes always land in the pending divisor.
module div_channel #(
   parameter int                CNT_W   = clk_div_pkg::CNT_W,
   parameter logic [CNT_W-1:0]  DEF_DIV = CNT_W'(2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             cfgWe,
   input  logic [CNT_W-1:0] cfgDiv,
   output logic             tick,
   output logic             square,
   output logic             active
);
   import clk_div_pkg::*;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] activeDiv;
   logic [CNT_W-1:0] pendingDiv;
   logic [CNT_W-1:0] pendNext;
   logic             atTerm;

   // A write on this edge overrides the stored pending value, so a write that
   // coincides with terminal count is the divisor that gets loaded.
   assign pendNext = cfgWe ? cfgDiv : pendingDiv;

   // Only N-1 is compared, so the largest divisor never needs an extra counter bit.
   assign atTerm = (activeDiv != '0) && (cnt == activeDiv - CNT_W'(1));

   assign active = (activeDiv != '0);

   // Counter, divisor hand-over and strobe registers; sync outranks everything but reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         tick       <= 1'b0;
         square     <= 1'b0;
         activeDiv  <= DEF_DIV;
         pendingDiv <= DEF_DIV;
      end else begin
         pendingDiv <= pendNext;
         if (sync) begin
            cnt       <= '0;
            tick      <= 1'b0;
            square    <= 1'b0;
            activeDiv <= pendNext;
         end else if (!en) begin
            tick <= 1'b0;
         end else if (activeDiv == '0) begin
            // Stopped channel picks up whatever was programmed and restarts from zero
            activeDiv <= pendingDiv;
            cnt       <= '0;
            tick      <= 1'b0;
         end else if (atTerm) begin
            cnt       <= '0;
            tick      <= 1'b1;
            square    <= ~square;
            activeDiv <= pendNext;
         end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/rate_divider_bank.sv
// Bank of NUM_CH independent rate dividers sharing one clock, enable and phase sync.
// Latency: outputs registered; divisor writes reach the pending register on the next edge.
// Backpressure: none; out-of-range channel writes are dropped.
module rate_divider_bank #(
   parameter int                       NUM_CH  = 4,
   parameter int                       CNT_W   = clk_div_pkg::CNT_W,
   parameter int                       CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter logic [NUM_CH*CNT_W-1:0]  DEF_DIV = clk_div_pkg::packDefDiv(
      clk_div_pkg::VGA_DIV, clk_div_pkg::SEG_DIV,
      clk_div_pkg::HZ1_DIV, clk_div_pkg::CHAR_DIV)
) (
   input  logic               clk,
   input  logic               rst,
   rate_divider_bank_if.slave bus
);
   import clk_div_pkg::*;

   logic [NUM_CH-1:0] chWe;

   for (genvar g = 0; g < NUM_CH; g++) begin : gCh
      // Channel numbers beyond NUM_CH match no slot, so such writes vanish here
      assign chWe[g] = bus.cfg_we && (bus.cfg_ch == CH_W'(g));

      div_channel #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV[g*CNT_W +: CNT_W])
      ) uCh (
         .clk    (clk),
         .rst    (rst),
         .en     (bus.en),
         .sync   (bus.sync),
         .cfgWe  (chWe[g]),
         .cfgDiv (bus.cfg_div),
         .tick   (bus.tick[g]),
         .square (bus.square[g]),
         .active (bus.active[g])
      );
   end

endmodule

// File: tb/tb_rate_divider_bank.sv
// Randomised and directed stimulus against a count-down reference model, scoreboarded.
// Latency: expected outputs are queued at drive time and checked just after the next edge.
// Backpressure: n/a.
module tb_rate_divider_bank;

   localparam int NCH = 3;
   localparam int CW  = 32;
   localparam int CHW = 2;

   logic clk;
   logic rst;

   rate_divider_bank_if #(.NUM_CH(NCH), .CNT_W(CW), .CH_W(CHW)) bus ();

   rate_divider_bank #(
      .NUM_CH  (NCH),
      .CNT_W   (CW),
      .CH_W    (CHW),
      .DEF_DIV ({32'd300, 32'd100, 32'd2})
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned defN [NCH] = '{2, 100, 300};

   // Reference model: cycles remaining until next tick, plus divisors and outputs
   int unsigned mAct  [NCH];
   int unsigned mPend [NCH];
   int unsigned mRem  [NCH];
   bit          mTick [NCH];
   bit          mSq   [NCH];

   logic [3*NCH-1:0] expQ [$];

   int total = 0;
   int bad   = 0;
   int cycNo = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3*NCH-1:0] expVec();
      logic [3*NCH-1:0] v;
      v = '0;
      for (int c = 0; c < NCH; c++) begin
         v[c]         = mTick[c];
         v[NCH + c]   = mSq[c];
         v[2*NCH + c] = (mAct[c] != 0);
      end
      return v;
   endfunction

   task automatic modelReset();
      for (int c = 0; c < NCH; c++) begin
         mAct[c]  = defN[c];
         mPend[c] = defN[c];
         mRem[c]  = defN[c];
         mTick[c] = 1'b0;
         mSq[c]   = 1'b0;
      end
   endtask

   task automatic modelStep(input bit e, input bit s, input bit w,
                            input int ch, input int unsigned d);
      for (int c = 0; c < NCH; c++) begin
         int unsigned np;
         np = (w && ch == c) ? d : mPend[c];
         if (s) begin
            mAct[c] = np; mRem[c] = np; mTick[c] = 1'b0; mSq[c] = 1'b0;
         end else if (!e) begin
            mTick[c] = 1'b0;
         end else if (mAct[c] == 0) begin
            mAct[c] = mPend[c]; mRem[c] = mPend[c]; mTick[c] = 1'b0;
         end else if (mRem[c] == 1) begin
            mTick[c] = 1'b1; mSq[c] = !mSq[c]; mAct[c] = np; mRem[c] = np;
         end else begin
            mRem[c] = mRem[c] - 1; mTick[c] = 1'b0;
         end
         mPend[c] = np;
      end
   endtask

   // Drive inputs for the coming edge and queue what the outputs must be after it
   task automatic drive(input bit e, input bit s, input bit w,
                        input int ch, input int unsigned d);
      bus.en      = e;
      bus.sync    = s;
      bus.cfg_we  = w;
      bus.cfg_ch  = CHW'(ch);
      bus.cfg_div = CW'(d);
      modelStep(e, s, w, ch, d);
      expQ.push_back(expVec());
   endtask

   task automatic cyc(input bit e, input bit s, input bit w,
                      input int ch, input int unsigned d);
      @(negedge clk);
      drive(e, s, w, ch, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic checkNow(input string name, input logic [3*NCH-1:0] want);
      logic [3*NCH-1:0] got;
      got = {bus.active, bus.square, bus.tick};
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   // Async reset mid-run: outputs must clear before any clock edge
   task automatic midReset();
      @(negedge clk);
      #1 rst = 1'b1;
      #1 checkNow("async_reset", {{NCH{1'b1}}, {NCH{1'b0}}, {NCH{1'b0}}});
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      drive(1'b1, 1'b0, 1'b0, 0, 0);
   endtask

   // Monitor: compare DUT outputs against the queued expectation after each edge
   initial begin
      logic [3*NCH-1:0] want;
      forever begin
         @(posedge clk);
         #2;
         if (!rst && expQ.size() > 0) begin
            want = expQ.pop_front();
            cycNo++;
            checkNow($sformatf("outputs_cycle%0d", cycNo), want);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      rst = 1'b0;
      bus.en = 1'b0; bus.sync = 1'b0; bus.cfg_we = 1'b0;
      bus.cfg_ch = '0; bus.cfg_div = '0;
      #1 rst = 1'b1;
      #2 checkNow("reset_state", {{NCH{1'b1}}, {NCH{1'b0}}, {NCH{1'b0}}});

      // Release and run on defaults
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      drive(1'b1, 1'b0, 1'b0, 0, 0);
      idle(30);

      // Divide-by-one on ch1, then period 3
      cyc(1'b1, 1'b0, 1'b1, 1, 1);
      idle(110);
      cyc(1'b1, 1'b0, 1'b1, 1, 3);
      idle(10);

      // Mid-count reprogram of ch2
      guard = 0;
      while (mRem[2] != 60 && guard < 400) begin idle(1); guard++; end
      cyc(1'b1, 1'b0, 1'b1, 2, 5);
      idle(80);

      // Write exactly on ch1 terminal count
      guard = 0;
      while (mRem[1] != 1 && guard < 10) begin idle(1); guard++; end
      cyc(1'b1, 1'b0, 1'b1, 1, 7);
      idle(20);

      // Stop ch0, then restart with 4
      cyc(1'b1, 1'b0, 1'b1, 0, 0);
      idle(6);
      cyc(1'b1, 1'b0, 1'b1, 0, 4);
      idle(12);

      // Sync at arbitrary phase, freeze, resume
      idle(3);
      cyc(1'b1, 1'b1, 1'b0, 0, 0);
      idle(13);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0);
      idle(20);
      cyc(1'b0, 1'b1, 1'b1, 2, 6);
      idle(15);

      // Reset mid-count then an out-of-range write
      idle(7);
      midReset();
      idle(5);
      cyc(1'b1, 1'b0, 1'b1, 3, 1);
      idle(20);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0),
             ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
             $urandom_range(0, 9));
      end

      // Drain scoreboard with a bounded wait
      guard = 0;
      while (expQ.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
      #3;
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", expQ.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
